// File: rtl/ad9866_pkg.sv
// Shared constants, reset image and FSM state type for the AD9866 SPI responder.
package ad9866_pkg;

    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] RX_GAIN_ADDR = 5'h09;
    localparam logic [ADDR_W-1:0] TX_GAIN_ADDR = 5'h0A;

    typedef logic [0:31][7:0] reg_table_t;

    // Element 0 is leftmost: entries 0..8 zero, 0x09/0x0A = 0x7F, 0x0B..0x1F zero.
    localparam reg_table_t REG_RESET_TABLE = {{9{8'h00}}, 8'h7F, 8'h7F, {21{8'h00}}};

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} spi_rsp_state_t;

endpackage

// File: rtl/ad9866_spi_responder_if.sv
// 4-wire SPI configuration bus between the config master and the AD9866 responder.
interface ad9866_spi_responder_if;
    logic sclk;
    logic sen_n;
    logic sdio;
    logic sdo;
    logic sdo_oe;

    modport master (output sclk, output sen_n, output sdio, input sdo, input sdo_oe);
    modport slave  (input sclk, input sen_n, input sdio, output sdo, output sdo_oe);
endinterface

// File: rtl/spi_edge_sync.sv
// Synchroniser for one asynchronous SPI input plus rise/fall detection on the synced value.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // No reset: the chain keeps tracking the pins so a reset never fabricates an edge.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        dly_q  <= sync_q[SYNC_STAGES-1];
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/ad9866_spi_responder.sv
// AD9866 SPI configuration responder: frame decode, register image, readback and gain outputs.
module ad9866_spi_responder
    import ad9866_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    ad9866_spi_responder_if.slave    spi,
    output logic                     wr_stb,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [7:0]               wr_data,
    output logic                     frame_err,
    output logic [5:0]               rx_gain,
    output logic [5:0]               tx_gain
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic sen_s, sen_rise, sen_fall;
    logic sdio_s, sdio_rise, sdio_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .d_i(spi.sclk), .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sen (
        .clk(clk), .d_i(spi.sen_n), .sync_o(sen_s), .rise_o(sen_rise), .fall_o(sen_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdio (
        .clk(clk), .d_i(spi.sdio), .sync_o(sdio_s), .rise_o(sdio_rise), .fall_o(sdio_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, sen_s, sdio_rise, sdio_fall};

    spi_rsp_state_t     state_q, state_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [15:0]        shreg_q, shreg_d;
    logic [7:0]         rdbyte_q, rdbyte_d;
    logic               rd_en_q, rd_en_d;
    logic               sdo_q, sdo_d;
    logic               sdo_oe_q, sdo_oe_d;
    logic               wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               frame_err_q, frame_err_d;
    logic [7:0]         regs_q [NUM_REGS];
    logic [7:0]         regs_d [NUM_REGS];

    logic [15:0]        shift_nxt;
    logic [ADDR_W-1:0]  frm_addr;

    assign shift_nxt = {shreg_q[14:0], sdio_s};
    assign frm_addr  = shift_nxt[12:8];

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        rdbyte_d    = rdbyte_q;
        rd_en_d     = rd_en_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = sdo_oe_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        regs_d      = regs_q;

        unique case (state_q)
            IDLE: begin
                if (sen_fall) begin
                    state_d  = SHIFT;
                    bitcnt_d = 4'd0;
                    shreg_d  = 16'h0000;
                    rd_en_d  = 1'b0;
                    sdo_oe_d = 1'b0;
                    sdo_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shreg_d  = shift_nxt;
                    bitcnt_d = bitcnt_q + 4'd1;
                    // After the 8th rise the low byte of shift_nxt is {R/W, rsvd, addr}.
                    if (bitcnt_q == 4'd7) begin
                        rd_en_d  = shift_nxt[7];
                        rdbyte_d = (32'(shift_nxt[4:0]) < NUM_REGS) ? regs_q[shift_nxt[4:0]]
                                                                     : 8'h00;
                    end
                    if (bitcnt_q == 4'd15) begin
                        // A coincident sen_n rise is folded in here so the frame still commits.
                        state_d = sen_rise ? IDLE : HOLD;
                        if (sen_rise) begin
                            sdo_oe_d = 1'b0;
                            sdo_d    = 1'b0;
                        end
                        if (!shift_nxt[15] && (32'(frm_addr) < NUM_REGS)) begin
                            regs_d[frm_addr] = shift_nxt[7:0];
                            wr_stb_d         = 1'b1;
                            wr_addr_d        = frm_addr;
                            wr_data_d        = shift_nxt[7:0];
                        end
                    end else if (sen_rise) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                        sdo_oe_d    = 1'b0;
                        sdo_d       = 1'b0;
                    end
                end else if (sen_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    sdo_oe_d    = 1'b0;
                    sdo_d       = 1'b0;
                end else if (sclk_fall && rd_en_q && bitcnt_q[3]) begin
                    // Falls 8..15 present rdbyte bits 7..0.
                    sdo_oe_d = 1'b1;
                    sdo_d    = rdbyte_q[~bitcnt_q[2:0]];
                end
            end
            HOLD: begin
                if (sen_rise) begin
                    state_d  = IDLE;
                    sdo_oe_d = 1'b0;
                    sdo_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= 4'd0;
            shreg_q     <= 16'h0000;
            rdbyte_q    <= 8'h00;
            rd_en_q     <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= REG_RESET_TABLE[i];
            end
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            rdbyte_q    <= rdbyte_d;
            rd_en_q     <= rd_en_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    assign spi.sdo    = sdo_q;
    assign spi.sdo_oe = sdo_oe_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_err  = frame_err_q;
    assign rx_gain    = regs_q[RX_GAIN_ADDR][5:0];
    assign tx_gain    = regs_q[TX_GAIN_ADDR][5:0];

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Directed bench for the AD9866 SPI responder: writes, readback, framing errors and reset.
module tb_ad9866_spi_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_stb;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic [5:0] rx_gain;
    logic [5:0] tx_gain;

    ad9866_spi_responder_if bus ();

    ad9866_spi_responder #(.NUM_REGS(20), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi(bus), .wr_stb(wr_stb), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err), .rx_gain(rx_gain), .tx_gain(tx_gain)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int half = 4;
    logic [5:0]  rx_at_stb = 6'h00;
    logic [12:0] stb_log [$];

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cnt++;
            stb_log.push_back({wr_addr, wr_data});
            rx_at_stb = rx_gain;
        end
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int rst_bit,
                            output logic [7:0] rd, output logic oe_ok);
        rd    = 8'h00;
        oe_ok = 1'b1;
        @(negedge clk);
        bus.sen_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.sdio = frame[15-i];
            repeat (half) @(negedge clk);
            if (i >= 8) begin
                rd = {rd[6:0], bus.sdo};
                if (!bus.sdo_oe) oe_ok = 1'b0;
            end else if (bus.sdo_oe) begin
                oe_ok = 1'b0;
            end
            bus.sclk = 1'b1;
            if (i == rst_bit) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                repeat (half - 1) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            bus.sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        bus.sen_n = 1'b1;
        repeat (half + 2) @(negedge clk);
        if (bus.sdo_oe) oe_ok = 1'b0;
    endtask

    task automatic spi_read(input logic [4:0] addr, output logic [7:0] rd, output logic oe_ok);
        spi_xfer({3'b100, addr, 8'h00}, 16, -1, rd, oe_ok);
    endtask

    logic [7:0] rd;
    logic       oe_ok;
    logic [7:0] exp_img [20];
    int         s0, e0;

    initial begin
        reset     = 1'b1;
        bus.sclk  = 1'b0;
        bus.sen_n = 1'b1;
        bus.sdio  = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rx_gain", 16'(rx_gain), 16'h3F);
        chk("rst_tx_gain", 16'(tx_gain), 16'h3F);
        chk("rst_wr_stb", 16'(wr_stb), 16'h0);
        chk("rst_sdo_oe", 16'(bus.sdo_oe), 16'h0);
        chk("rst_sdo", 16'(bus.sdo), 16'h0);
        chk("rst_frame_err", 16'(frame_err), 16'h0);
        chk("rst_wr_addr", 16'(wr_addr), 16'h0);
        chk("rst_wr_data", 16'(wr_data), 16'h0);

        // Write 0x09 = 0x55
        s0 = stb_cnt;
        spi_xfer(16'h0955, 16, -1, rd, oe_ok);
        chk("w09_stb_count", 16'(stb_cnt - s0), 16'd1);
        chk("w09_wr_addr", 16'(wr_addr), 16'h09);
        chk("w09_wr_data", 16'(wr_data), 16'h55);
        chk("w09_rx_gain", 16'(rx_gain), 16'h15);
        chk("w09_rx_at_stb", 16'(rx_at_stb), 16'h15);
        chk("w09_tx_gain", 16'(tx_gain), 16'h3F);

        // Write 0x0A = 0x6A then read it back
        spi_xfer(16'h0A6A, 16, -1, rd, oe_ok);
        chk("w0a_tx_gain", 16'(tx_gain), 16'h2A);
        s0 = stb_cnt;
        spi_xfer(16'h8A00, 16, -1, rd, oe_ok);
        chk("r0a_data", 16'(rd), 16'h6A);
        chk("r0a_oe_window", 16'(oe_ok), 16'h1);
        chk("r0a_no_stb", 16'(stb_cnt - s0), 16'd0);

        // Unimplemented address
        s0 = stb_cnt;
        spi_xfer(16'h1FAB, 16, -1, rd, oe_ok);
        chk("w1f_no_stb", 16'(stb_cnt - s0), 16'd0);
        spi_read(5'h1F, rd, oe_ok);
        chk("r1f_data", 16'(rd), 16'h00);
        for (int a = 0; a < 20; a++) exp_img[a] = 8'h00;
        exp_img[9]  = 8'h55;
        exp_img[10] = 8'h6A;
        for (int a = 0; a < 20; a++) begin
            spi_read(5'(a), rd, oe_ok);
            chk($sformatf("img_after_1f[%0d]", a), 16'(rd), 16'(exp_img[a]));
        end

        // Short frame after a clean reset
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        s0 = stb_cnt;
        e0 = err_cnt;
        spi_xfer(16'h0933, 9, -1, rd, oe_ok);
        chk("short_err_count", 16'(err_cnt - e0), 16'd1);
        chk("short_no_stb", 16'(stb_cnt - s0), 16'd0);
        spi_read(5'h09, rd, oe_ok);
        chk("short_reg09", 16'(rd), 16'h7F);
        s0 = stb_cnt;
        spi_xfer(16'h0901, 16, -1, rd, oe_ok);
        chk("after_short_stb", 16'(stb_cnt - s0), 16'd1);
        chk("after_short_rx_gain", 16'(rx_gain), 16'h01);

        // Reset pulse in the middle of a frame
        spi_xfer(16'h0A05, 16, -1, rd, oe_ok);
        s0 = stb_cnt;
        e0 = err_cnt;
        spi_xfer(16'h0A22, 16, 5, rd, oe_ok);
        chk("midrst_no_stb", 16'(stb_cnt - s0), 16'd0);
        chk("midrst_no_err", 16'(err_cnt - e0), 16'd0);
        chk("midrst_rx_gain", 16'(rx_gain), 16'h3F);
        chk("midrst_tx_gain", 16'(tx_gain), 16'h3F);
        s0 = stb_cnt;
        spi_xfer(16'h0A11, 16, -1, rd, oe_ok);
        chk("midrst_next_stb", 16'(stb_cnt - s0), 16'd1);
        chk("midrst_next_tx_gain", 16'(tx_gain), 16'h11);

        // 20 back-to-back writes at the fastest legal sclk
        half = 3;
        stb_log.delete();
        s0 = stb_cnt;
        for (int a = 0; a < 20; a++) begin
            exp_img[a] = 8'(a * 7 + 3);
            spi_xfer({3'b000, 5'(a), exp_img[a]}, 16, -1, rd, oe_ok);
        end
        chk("b2b_stb_count", 16'(stb_cnt - s0), 16'd20);
        for (int a = 0; a < 20; a++) begin
            if (a < stb_log.size()) chk($sformatf("b2b_order[%0d]", a), 16'(stb_log[a]),
                                        16'({5'(a), exp_img[a]}));
            else chk($sformatf("b2b_missing[%0d]", a), 16'h1, 16'h0);
        end
        chk("b2b_rx_gain", 16'(rx_gain), 16'h02);
        chk("b2b_tx_gain", 16'(tx_gain), 16'h09);
        for (int a = 0; a < 20; a++) begin
            spi_read(5'(a), rd, oe_ok);
            chk($sformatf("b2b_img[%0d]", a), 16'(rd), 16'(exp_img[a]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
